fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_next_pc_calc.sv | 29 ++
 rtl/fetch_unit.sv | 72 +++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_BEQ           = 6'h04;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory port, downstream instruction handoff and pc/retire status.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] retired;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, retired,
        input  imem_ready, imem_rdata, instr_ready, branch, zero
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, retired,
        output imem_ready, imem_rdata, instr_ready, branch, zero
    );

endinterface

// File: rtl/fetch_next_pc_calc.sv
// Next-pc selection: jump beats taken branch, which beats the sequential pc+4.
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_target;

    assign pc_plus4    = pc + 32'd4;
    assign br_offset   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (instr[31:26] == OP_J) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: request a word, hold it until consumed, then advance pc.
//   state    | meaning
//   ST_FETCH | imem_req high, waiting for imem_ready to capture the word
//   ST_HOLD  | instr_valid high, waiting for instr_ready to consume it
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic [31:0]  retired_d;
    logic         imem_req_q;
    logic         instr_valid_q;
    logic [31:0]  next_pc;

    // branch/zero only matter in the consume cycle, so they feed the calc unregistered
    next_pc_calc u_next_pc_calc (
        .pc      (pc_q),
        .instr   (instr_q),
        .branch  (bus.branch),
        .zero    (bus.zero),
        .next_pc (next_pc)
    );

    always_comb begin
        pc_d      = next_pc;
        retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            retired_q     <= 32'h0;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
        end else if (state_q == ST_FETCH) begin
            if (bus.imem_ready) begin
                instr_q       <= bus.imem_rdata;
                state_q       <= ST_HOLD;
                imem_req_q    <= 1'b0;
                instr_valid_q <= 1'b1;
            end
        end else begin
            if (bus.instr_ready) begin
                pc_q          <= pc_d;
                retired_q     <= retired_d;
                state_q       <= ST_FETCH;
                imem_req_q    <= 1'b1;
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.retired     = retired_q;

endmodule
